// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: receiver FSM state encoding and bit-timing helpers,
// kept here so a later transmitter can derive identical bit periods.
package uart_byte_rx_pkg;

   typedef enum logic [2:0] {
      ARM,
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } rx_state_t;

   localparam int DEF_CLK_FREQ = 100_000_000;
   localparam int DEF_BAUD     = 115200;

   // The synchronizer comes out of reset holding 1 for two cycles, so ARM needs
   // the line high for longer than that before it trusts it.
   localparam int ARM_HIGH_CYCLES = 4;

   // Clocks per serial bit, truncated.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Clocks from the start edge to the centre of the start bit.
   function automatic int half_bit(input int clk_freq, input int baud);
      return clks_per_bit(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// value loaded on reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   // Two back-to-back flops to resolve metastability on the incoming line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_p0 <= RST_VAL;
         sync_p1 <= RST_VAL;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1, LSB first, start-bit glitch rejection, stop-bit
// framing check, and an ARM state that refuses a line held low out of reset.
module uart_byte_rx
   import uart_byte_rx_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_HIGH_CYCLES - 1);

   rx_state_t        state;
   rx_state_t        state_nxt;
   logic             rx_sync;
   logic             rx_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   logic             cnt_clr;
   logic             idx_clr;
   logic             idx_inc;
   logic             shift_en;
   logic             valid_nxt;
   logic             ferr_nxt;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (i_rx),
      .q     (rx_sync)
   );

   // One-cycle-delayed copy of the synchronized line for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_prev <= 1'b1;
      end else begin
         rx_prev <= rx_sync;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle strobes; the counter runs unless a state clears it.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      shift_en  = 1'b0;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         ARM: begin
            if (!rx_sync) begin
               cnt_clr = 1'b1;
            end else if (cnt == ARM_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            cnt_clr = 1'b1;
            idx_clr = 1'b1;
            if (rx_prev && !rx_sync) begin
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  idx_inc = 1'b1;
               end
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_clr = 1'b1;
               if (rx_sync) begin
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = RECOVER;
               end
            end
         end
         RECOVER: begin
            cnt_clr = 1'b1;
            if (rx_sync) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = ARM;
         end
      endcase
   end

   // Cycle counter: restarts at every sample point, otherwise counts up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Data bit index, 0..7 across the DATA state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx <= 3'd0;
      end else if (idx_clr) begin
         bit_idx <= 3'd0;
      end else if (idx_inc) begin
         bit_idx <= bit_idx + 3'd1;
      end
   end

   // Shift register: each sample enters at the MSB so bit 0 ends at the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift <= 8'h00;
      end else if (shift_en) begin
         shift <= {rx_sync, shift[7:1]};
      end
   end

   // Registered outputs: o_data only moves together with an o_valid pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_valid     <= valid_nxt;
         o_frame_err <= ferr_nxt;
         if (valid_nxt) begin
            o_data <= shift;
         end
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 100 MHz / 115200 baud (868 clocks per bit).
module tb_uart_byte_rx;

   localparam int CPB = 868;
   localparam int NV  = 6;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       i_rx  = 1'b1;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_busy;

   always #5 clk = ~clk;

   uart_byte_rx #(
      .CLK_FREQ (100_000_000),
      .BAUD     (115200)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      logic       exp_valid;
      logic       exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      logic        v;
      logic        f;
      logic [7:0]  d;
      int unsigned cyc;
   } ev_t;

   ev_t         obs[$];
   vec_t        vecs[NV];
   int unsigned cyc          = 0;
   int          n_checks     = 0;
   int          n_fail       = 0;
   int          overlap_cnt  = 0;
   int          unstable_cnt = 0;
   logic [7:0]  prev_data    = 8'h00;
   int unsigned ev_cyc[NV];

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: records every pulse and watches the o_data/pulse rules.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid || o_frame_err)
            obs.push_back('{v: o_valid, f: o_frame_err, d: o_data, cyc: cyc});
         if (o_valid && o_frame_err) overlap_cnt++;
         if (o_data !== prev_data && !o_valid) unstable_cnt++;
      end
      prev_data = o_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      i_rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
      drive_bit(stop, CPB);
   endtask

   // Exactly one pulse expected since the last call; returns its cycle stamp.
   task automatic expect_event(input string name, input logic v, input logic f,
                               input logic [7:0] d, output int unsigned when);
      ev_t e;
      when = 0;
      check({name, " pulse count"}, obs.size(), 1);
      if (obs.size() > 0) begin
         e    = obs.pop_front();
         when = e.cyc;
         check({name, " o_valid"}, e.v, v);
         check({name, " o_frame_err"}, e.f, f);
         check({name, " o_data"}, e.d, d);
      end
      obs.delete();
   endtask

   initial begin
      logic [7:0]  model_good;
      logic [7:0]  b3c;
      int unsigned t;
      int unsigned gap;

      // Stimulus table; expected outputs come from the framing rule below.
      vecs[0] = '{data: 8'h41, stop: 1'b1, gap: 0, exp_valid: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
      vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_valid: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 0, exp_valid: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
      vecs[3] = '{data: 8'($urandom), stop: 1'($urandom), gap: 0, exp_valid: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
      vecs[4] = '{data: 8'hA5, stop: 1'b0, gap: 100, exp_valid: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
      vecs[5] = '{data: 8'hE0, stop: 1'b1, gap: 50, exp_valid: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};

      // Reference model: a high stop bit delivers the byte; a low one flags a
      // framing error while the output keeps the last good byte (0 after reset).
      model_good = 8'h00;
      for (int i = 0; i < NV; i++) begin
         vecs[i].exp_valid = vecs[i].stop;
         vecs[i].exp_ferr  = !vecs[i].stop;
         if (vecs[i].stop) model_good = vecs[i].data;
         vecs[i].exp_data = model_good;
      end

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset o_data", o_data, 8'h00);
      check("reset o_valid", o_valid, 1'b0);
      check("reset o_frame_err", o_frame_err, 1'b0);
      check("reset o_busy (ARM)", o_busy, 1'b1);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("idle after arm o_busy", o_busy, 1'b0);

      // Table: back-to-back bytes, random byte, framing error, recovery
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].gap > 0) drive_bit(1'b1, vecs[i].gap);
         send_frame(vecs[i].data, vecs[i].stop);
         expect_event($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ferr,
                      vecs[i].exp_data, ev_cyc[i]);
      end
      gap = ev_cyc[1] - ev_cyc[0];
      check("back-to-back spacing ~8680", (gap >= 8678 && gap <= 8682), 1'b1);

      // Start-bit glitch of 200 cycles on an idle line
      drive_bit(1'b1, 100);
      drive_bit(1'b0, 200);
      check("glitch o_busy in START", o_busy, 1'b1);
      drive_bit(1'b1, 240);
      check("glitch back to IDLE by 440", o_busy, 1'b0);
      drive_bit(1'b1, 500);
      check("glitch no pulse", obs.size(), 0);

      // Reset in the middle of data bit 4 of 0x3C
      b3c = 8'h3C;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(b3c[i], CPB);
      drive_bit(b3c[4], CPB / 2);
      rst_n = 1'b0;
      i_rx  = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("midbyte reset o_busy", o_busy, 1'b1);
      check("midbyte reset o_data", o_data, 8'h00);
      rst_n = 1'b1;
      drive_bit(1'b1, 200);
      check("aborted byte no pulse", obs.size(), 0);
      send_frame(8'h11, 1'b1);
      expect_event("after reset 0x11", 1'b1, 1'b0, 8'h11, t);

      // Line held low through reset release
      i_rx  = 1'b0;
      rst_n = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_bit(1'b0, 2000);
      check("low line stays in ARM", o_busy, 1'b1);
      check("low line no pulse", obs.size(), 0);
      drive_bit(1'b1, 50);
      check("line high reaches IDLE", o_busy, 1'b0);
      send_frame(8'hFF, 1'b1);
      expect_event("after held-low 0xFF", 1'b1, 1'b0, 8'hFF, t);

      // Whole-run pulse and data-stability rules
      drive_bit(1'b1, 100);
      check("no stray pulses", obs.size(), 0);
      check("valid/frame_err overlap", overlap_cnt, 0);
      check("o_data changed without o_valid", unstable_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
